// File: rtl/raid_cmd_scheduler_if.sv
// Command, disk-health and backend handshake bundle for raid_cmd_scheduler.
// The master modport drives commands and completions; the slave is the scheduler.
interface raid_cmd_scheduler_if #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned NUM_DISKS = 3,
  parameter int unsigned QDEPTH    = 4
);
  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

  logic                 cmd_valid;
  logic                 cmd_op;
  logic [DATA_W-1:0]    cmd_data;
  logic [ADDR_W-1:0]    cmd_addr;
  logic                 cmd_ready;
  logic [NUM_DISKS-1:0] disk_stat;
  logic                 wr_done;
  logic                 rd_done;
  logic                 raid_done;
  logic                 wr_en_out;
  logic                 rd_en_out;
  logic [DATA_W-1:0]    write_data_out;
  logic [ADDR_W-1:0]    address_out;
  logic                 raid_start;
  logic [NUM_DISKS-1:0] disk_stat_out;
  logic                 busy;
  logic                 timeout_err;
  logic [CNT_W-1:0]     q_count;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_addr, disk_stat, wr_done, rd_done, raid_done,
    input  cmd_ready, wr_en_out, rd_en_out, write_data_out, address_out, raid_start,
           disk_stat_out, busy, timeout_err, q_count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_addr, disk_stat, wr_done, rd_done, raid_done,
    output cmd_ready, wr_en_out, rd_en_out, write_data_out, address_out, raid_start,
           disk_stat_out, busy, timeout_err, q_count
  );
endinterface

// File: rtl/raid_cmd_scheduler.sv
// Queued front-end scheduler: FIFO of write/read commands, disk-health changes take
// priority, one backend operation in flight at a time with a watchdog.
module raid_cmd_scheduler #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned NUM_DISKS = 3,
  parameter int unsigned QDEPTH    = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input logic                 clk,
  input logic                 reset,
  raid_cmd_scheduler_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = 1 + DATA_W + ADDR_W;
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StRaid} state_e;

  logic [ENT_W-1:0]  fifo_mem [QDEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              push, pop, fifo_empty;
  logic              head_op;
  logic [DATA_W-1:0] head_data;
  logic [ADDR_W-1:0] head_addr;

  state_e               state_q, state_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [NUM_DISKS-1:0] disk_stat_r, dstat_out_q, dstat_out_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic                 raid_start_q, raid_start_d, timeout_q, timeout_d;
  logic                 raid_req, done_match;

  assign bus.cmd_ready = (count_q != CNT_W'(QDEPTH));
  assign fifo_empty    = (count_q == '0);
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign {head_op, head_data, head_addr} = fifo_mem[rd_ptr_q];
  assign raid_req      = (disk_stat_r != dstat_out_q);

  // No bypass: the FSM only ever sees registered FIFO contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(QDEPTH); i++) fifo_mem[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr_q] <= {bus.cmd_op, bus.cmd_data, bus.cmd_addr};
        wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  always_comb begin
    unique case (state_q)
      StWrite: done_match = bus.wr_done;
      StRead:  done_match = bus.rd_done;
      StRaid:  done_match = bus.raid_done;
      default: done_match = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    wd_d         = wd_q;
    dstat_out_d  = dstat_out_q;
    wdata_d      = wdata_q;
    addr_d       = addr_q;
    wr_en_d      = 1'b0;
    rd_en_d      = 1'b0;
    raid_start_d = 1'b0;
    timeout_d    = 1'b0;
    pop          = 1'b0;

    if (state_q == StIdle) begin
      if (raid_req) begin
        state_d      = StRaid;
        dstat_out_d  = disk_stat_r;
        raid_start_d = 1'b1;
        wd_d         = '0;
      end else if (!fifo_empty) begin
        pop    = 1'b1;
        addr_d = head_addr;
        wd_d   = '0;
        if (head_op) begin
          state_d = StRead;
          rd_en_d = 1'b1;
        end else begin
          state_d = StWrite;
          wr_en_d = 1'b1;
          wdata_d = head_data;
        end
      end
    end else begin
      // wd_q == 0 marks the issue-pulse cycle, where a done is not yet honoured.
      if (done_match && (wd_q != '0)) begin
        state_d = StIdle;
      end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
        state_d   = StIdle;
        timeout_d = 1'b1;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      wd_q         <= '0;
      disk_stat_r  <= '1;
      dstat_out_q  <= '1;
      wdata_q      <= '0;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      raid_start_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wd_q         <= wd_d;
      disk_stat_r  <= bus.disk_stat;
      dstat_out_q  <= dstat_out_d;
      wdata_q      <= wdata_d;
      addr_q       <= addr_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      raid_start_q <= raid_start_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.wr_en_out      = wr_en_q;
  assign bus.rd_en_out      = rd_en_q;
  assign bus.write_data_out = wdata_q;
  assign bus.address_out    = addr_q;
  assign bus.raid_start     = raid_start_q;
  assign bus.disk_stat_out  = dstat_out_q;
  assign bus.busy           = (state_q != StIdle);
  assign bus.timeout_err    = timeout_q;
  assign bus.q_count        = count_q;
endmodule

// File: tb/tb_raid_cmd_scheduler.sv
// Directed bench for raid_cmd_scheduler (QDEPTH=4, TIMEOUT=8); expected values are
// hand-derived from the cycle timing of the scheduler.
module tb_raid_cmd_scheduler;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  raid_cmd_scheduler_if #(.DATA_W(16), .ADDR_W(8), .NUM_DISKS(3), .QDEPTH(4)) bus ();

  raid_cmd_scheduler #(
    .DATA_W(16), .ADDR_W(8), .NUM_DISKS(3), .QDEPTH(4), .TIMEOUT(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic op, input logic [15:0] d, input logic [7:0] a);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    bus.cmd_addr  = a;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  logic       fill_op   [4];
  logic [7:0] fill_addr [4];
  logic [15:0] fill_wd  [4];

  initial begin
    total = 0;
    bad   = 0;
    fill_op   = '{1'b1, 1'b0, 1'b1, 1'b0};
    fill_addr = '{8'h21, 8'h22, 8'h23, 8'h24};
    fill_wd   = '{16'h1111, 16'h3333, 16'h3333, 16'h5555};
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 1'b0;
    bus.cmd_data  = '0;
    bus.cmd_addr  = '0;
    bus.disk_stat = 3'b111;
    bus.wr_done   = 1'b0;
    bus.rd_done   = 1'b0;
    bus.raid_done = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_wr_en", bus.wr_en_out, 0);
    chk("rst_rd_en", bus.rd_en_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_qcount", bus.q_count, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_dso", bus.disk_stat_out, 3'b111);
    chk("rst_raid_start", bus.raid_start, 0);
    chk("rst_timeout", bus.timeout_err, 0);
    reset = 1'b0;
    tick();

    // Single write
    push(1'b0, 16'hA5A5, 8'h10);
    chk("w1_qcount_push", bus.q_count, 1);
    chk("w1_no_bypass", bus.wr_en_out, 0);
    tick();
    chk("w1_wr_en", bus.wr_en_out, 1);
    chk("w1_wdata", bus.write_data_out, 16'hA5A5);
    chk("w1_addr", bus.address_out, 8'h10);
    chk("w1_busy", bus.busy, 1);
    chk("w1_qcount_pop", bus.q_count, 0);
    tick();
    chk("w1_pulse_1cyc", bus.wr_en_out, 0);
    tick();
    bus.wr_done = 1'b1;
    tick();
    bus.wr_done = 1'b0;
    chk("w1_busy_at_done", bus.busy, 0);
    chk("w1_wdata_hold", bus.write_data_out, 16'hA5A5);
    tick();

    // Queue fill: c0 issues, c1..c4 fill the FIFO, a sixth offer is refused
    push(1'b0, 16'h1111, 8'h20);
    push(1'b1, 16'hEEEE, 8'h21);
    chk("fill_c0_wr_en", bus.wr_en_out, 1);
    chk("fill_c0_addr", bus.address_out, 8'h20);
    chk("fill_c0_wdata", bus.write_data_out, 16'h1111);
    push(1'b0, 16'h3333, 8'h22);
    push(1'b1, 16'hEEEE, 8'h23);
    push(1'b0, 16'h5555, 8'h24);
    chk("fill_qcount_full", bus.q_count, 4);
    chk("fill_ready_low", bus.cmd_ready, 0);
    push(1'b0, 16'h6666, 8'h25);
    chk("fill_refused", bus.q_count, 4);
    bus.wr_done = 1'b1;
    tick();
    bus.wr_done = 1'b0;
    chk("fill_c0_done", bus.busy, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fill_rd_en%0d", i), bus.rd_en_out, 32'(fill_op[i]));
      chk($sformatf("fill_wr_en%0d", i), bus.wr_en_out, 32'(!fill_op[i]));
      chk($sformatf("fill_addr%0d", i), bus.address_out, fill_addr[i]);
      chk($sformatf("fill_wdata%0d", i), bus.write_data_out, fill_wd[i]);
      chk($sformatf("fill_qcount%0d", i), bus.q_count, 32'(3 - i));
      tick();
      if (fill_op[i]) bus.rd_done = 1'b1;
      else bus.wr_done = 1'b1;
      tick();
      bus.rd_done = 1'b0;
      bus.wr_done = 1'b0;
      chk($sformatf("fill_done%0d", i), bus.busy, 0);
      tick();
    end

    // RAID priority over the second queued read
    push(1'b1, 16'h0, 8'h30);
    push(1'b1, 16'h0, 8'h31);
    chk("raid_r0_rd_en", bus.rd_en_out, 1);
    chk("raid_r0_addr", bus.address_out, 8'h30);
    bus.disk_stat = 3'b101;
    bus.rd_done   = 1'b1;
    tick();
    bus.rd_done = 1'b0;
    chk("raid_done_in_pulse_ignored", bus.busy, 1);
    chk("raid_deferred", bus.raid_start, 0);
    chk("raid_dso_old", bus.disk_stat_out, 3'b111);
    tick();
    bus.rd_done = 1'b1;
    tick();
    bus.rd_done = 1'b0;
    chk("raid_r0_done", bus.busy, 0);
    tick();
    chk("raid_start", bus.raid_start, 1);
    chk("raid_dso_new", bus.disk_stat_out, 3'b101);
    chk("raid_before_r1", bus.rd_en_out, 0);
    chk("raid_qcount", bus.q_count, 1);
    tick();
    chk("raid_start_1cyc", bus.raid_start, 0);
    bus.raid_done = 1'b1;
    tick();
    bus.raid_done = 1'b0;
    tick();
    chk("raid_r1_rd_en", bus.rd_en_out, 1);
    chk("raid_r1_addr", bus.address_out, 8'h31);
    tick();
    bus.rd_done = 1'b1;
    tick();
    bus.rd_done = 1'b0;
    tick();
    tick();
    chk("raid_no_retrigger", bus.raid_start, 0);
    chk("raid_idle_after", bus.busy, 0);

    // Watchdog on a read with no rd_done; a stray wr_done is ignored
    push(1'b1, 16'h0, 8'h40);
    push(1'b0, 16'h7777, 8'h41);
    chk("to_rd_en", bus.rd_en_out, 1);
    tick();
    bus.wr_done = 1'b1;
    tick();
    bus.wr_done = 1'b0;
    repeat (5) tick();
    chk("to_busy_cycle8", bus.busy, 1);
    chk("to_not_yet", bus.timeout_err, 0);
    tick();
    chk("to_err", bus.timeout_err, 1);
    chk("to_busy_low", bus.busy, 0);
    tick();
    chk("to_err_1cyc", bus.timeout_err, 0);
    chk("to_next_wr_en", bus.wr_en_out, 1);
    chk("to_next_wdata", bus.write_data_out, 16'h7777);
    chk("to_next_addr", bus.address_out, 8'h41);

    // Push and pop on the same edge keep q_count
    push(1'b1, 16'h0, 8'h51);
    push(1'b1, 16'h0, 8'h52);
    push(1'b1, 16'h0, 8'h53);
    bus.wr_done = 1'b1;
    tick();
    bus.wr_done = 1'b0;
    chk("pp_qcount_before", bus.q_count, 3);
    push(1'b1, 16'h0, 8'h54);
    chk("pp_qcount_same", bus.q_count, 3);
    chk("pp_rd_en", bus.rd_en_out, 1);
    chk("pp_addr0", bus.address_out, 8'h51);
    for (int j = 0; j < 3; j++) begin
      tick();
      bus.rd_done = 1'b1;
      tick();
      bus.rd_done = 1'b0;
      tick();
      chk($sformatf("pp_rd_en%0d", j + 1), bus.rd_en_out, 1);
      chk($sformatf("pp_addr%0d", j + 1), bus.address_out, 32'(8'h52 + j));
      chk($sformatf("pp_qcount%0d", j + 1), bus.q_count, 32'(2 - j));
    end
    tick();
    bus.rd_done = 1'b1;
    tick();
    bus.rd_done = 1'b0;
    chk("pp_drained", bus.busy, 0);

    // Reset in the middle of a write with three commands queued
    push(1'b0, 16'h9999, 8'h60);
    push(1'b1, 16'h0, 8'h61);
    push(1'b1, 16'h0, 8'h62);
    push(1'b1, 16'h0, 8'h63);
    chk("mr_busy", bus.busy, 1);
    chk("mr_qcount", bus.q_count, 3);
    reset = 1'b1;
    #2;
    chk("mr_busy_rst", bus.busy, 0);
    chk("mr_qcount_rst", bus.q_count, 0);
    chk("mr_dso_rst", bus.disk_stat_out, 3'b111);
    chk("mr_wdata_rst", bus.write_data_out, 0);
    chk("mr_addr_rst", bus.address_out, 0);
    chk("mr_ready_rst", bus.cmd_ready, 1);
    bus.disk_stat = 3'b111;
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("mr_stays_idle", bus.busy, 0);
    chk("mr_no_issue", bus.rd_en_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
